// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_generator
// Purpose  : Sixteen-channel output driver. Each channel is forced low,
//            forced high, or follows one shared 8-bit PWM waveform produced
//            by a clock prescaler and a 256-step period counter.
// Options  : PWM_SYNC_UPDATE_EN - when defined, the duty cycle is shadowed
//            and only updated at period boundaries (glitch-free updates).
//            When undefined, the duty input is used live.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_generator #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_strobe
);

    localparam logic [15:0] c_div_last = 16'(CLK_DIV - 1);

    logic [15:0] w_en_out;
    logic [15:0] w_en_pwm;
    logic [15:0] r_div_cnt;
    logic [7:0]  r_step_cnt;
    logic        w_step_tick;
    logic [7:0]  w_duty_eff;
    logic        w_pwm_hi;
    logic [15:0] w_out_next;

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // A divide-by-one prescaler degenerates to a permanent step tick.
    generate
        if (CLK_DIV == 1) begin : g_no_prescale
            assign w_step_tick = 1'b1;
        end else begin : g_prescale
            assign w_step_tick = (r_div_cnt == c_div_last);
        end
    endgenerate

    // Prescaler and 256-step period counter; step_cnt wraps naturally at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_step_cnt <= '0;
        end else if (w_step_tick) begin
            r_div_cnt  <= '0;
            r_step_cnt <= r_step_cnt + 8'd1;
        end else begin
            r_div_cnt  <= r_div_cnt + 16'd1;
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0] r_duty_shadow;
    logic       r_first;
    logic       w_period_start;

    assign w_period_start = w_step_tick && (r_step_cnt == 8'hFF);

    // Duty shadow: captured on the first edge after reset release and on each
    // wrap edge, so every period runs with one consistent duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= '0;
            r_first       <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (r_first || w_period_start) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    // During the very first cycle after release the shadow has not been
    // loaded yet, so the live value it is about to capture is used instead.
    assign w_duty_eff = r_first ? pwm_duty_cycle : r_duty_shadow;
`else
    assign w_duty_eff = pwm_duty_cycle;
`endif

    // 0xFF is treated as full on so there is no single low step per period.
    assign w_pwm_hi   = (w_duty_eff == 8'hFF) || (r_step_cnt < w_duty_eff);

    // Output enable has priority; PWM mode only matters for enabled channels.
    assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_hi}});

    // Registered outputs; the strobe marks the cycle showing a period's first level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out           <= '0;
            period_strobe <= 1'b0;
        end else begin
            out           <= w_out_next;
            period_strobe <= (r_div_cnt == 16'd0) && (r_step_cnt == 8'd0);
        end
    end

endmodule
`default_nettype wire

// File: doc/pwm_generator.md
# pwm_generator

Sixteen-channel output driver that sits directly downstream of the SPI register block. It consumes the five configuration registers (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each channel is forced low, forced high, or driven by one shared 8-bit PWM waveform. The PWM waveform comes from a clock prescaler and a 256-step period counter.

## Interface
Parameters:
- CLK_DIV, default 13: clk cycles per PWM step; legal range 1..65535. PWM period = 256*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en_reg_out_7_0  input  8  output enables, channels 7..0.
- en_reg_out_15_8  input  8  output enables, channels 15..8.
- en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
- en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
- pwm_duty_cycle  input  8  duty: high steps per 256-step period; 0xFF means 100%.
- out  output  16  channel outputs (registered).
- period_strobe  output  1  one-cycle pulse on the first clk of each PWM period.

## Operation
- en_out[15:0] = {en_reg_out_15_8, en_reg_out_7_0}.
- en_pwm[15:0] = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
- Prescaler:
  - div_cnt, 16 bits, counts 0..CLK_DIV-1 and wraps to 0.
  - step_tick is asserted when div_cnt == CLK_DIV-1.
- Step counter:
  - step_cnt, 8 bits, increments on step_tick and wraps 255->0.
  - No other event changes it.
- Period start: step_tick with step_cnt == 255. On that cycle div_cnt -> 0 and step_cnt -> 0.
- Effective duty (duty_eff) depends on the build configuration; see Configuration.
- PWM level, combinational from current counters:
  - pwm_hi = (duty_eff == 8'hFF) | (step_cnt < duty_eff).
  - Duty 0x00 gives constant low.
  - Duty 0xFF gives constant high; there is no 255/256 glitch.
  - Duty N in 1..254 gives exactly N*CLK_DIV high clk cycles per period, starting at the beginning of the period.
- Per channel i, next value of out[i]:
  - en_out[i] == 0 -> 0. This has priority over en_pwm[i].
  - en_out[i] == 1 and en_pwm[i] == 0 -> 1.
  - en_out[i] == 1 and en_pwm[i] == 1 -> pwm_hi.
- All PWM-mode channels share one waveform and are phase-aligned.
- Enable inputs are used live, with no shadowing; a change takes effect at the next clk edge.
- Reset (asynchronous, and at any time including mid-period):
  - div_cnt = 0, step_cnt = 0, duty shadow = 0.
  - out = 16'h0000, period_strobe = 0.
  - After rst_n deasserts, the first period starts at div_cnt = 0, step_cnt = 0.

## Timing
- Latency: input register change -> out change is 1 clk (out registered).
- div_cnt and step_cnt are both 0 on the first clk after reset release.
- period_strobe:
  - Registered; high for exactly one clk.
  - Asserted in the cycle where div_cnt == 0 and step_cnt == 0, i.e. 1 clk after the wrap edge, coincident with out showing the new period's first level.
  - Also asserted in the first cycle after reset release.
- Period length: exactly 256*CLK_DIV clk. For CLK_DIV = 1 the prescaler is bypassed and step_tick is held at 1.
- Simultaneous events:
  - A duty write on the wrap edge: the new value is captured into the shadow (sync build).
  - A duty write with an enable change: both apply per the rules above.

## Configuration
- Macro: PWM_SYNC_UPDATE_EN.
- Defined:
  - duty_eff is an 8-bit shadow register loaded from pwm_duty_cycle only at period start and on reset release (value read at that edge).
  - A duty change mid-period takes effect at the next period boundary.
  - No partial or runt pulses.
- Undefined:
  - duty_eff = pwm_duty_cycle, used live; no shadow register is implemented.
  - A mid-period change takes effect on out 1 clk later.
  - One irregular period may result.

## Test plan
- Reset: hold rst_n = 0 with all inputs 0xFF -> out == 16'h0000, period_strobe == 0. Release -> period_strobe pulses on the first clk.
- Static modes: en_out = 16'h00FF, en_pwm = 16'hFF00 -> out == 16'h00FF after 1 clk. en_out = 16'hFFFF, en_pwm = 16'h0000 -> out == 16'hFFFF.
- Duty sweep, CLK_DIV = 13, channel 0 in PWM mode. For each duty below, measure over 3 periods; period_strobe spacing is 3328 clk.
  - duty 0x00 -> always 0.
  - duty 0x80 -> high 1664 clk per 3328.
  - duty 0x01 -> high 13 clk.
  - duty 0xFF -> always 1.
- Mid-period update, sync build: duty 0x40 -> 0xC0 written at step 100. Current period keeps 832 clk high; next period is 2496 clk high.
- Mid-period update, non-sync build: same stimulus -> out goes high 1 clk after the write and stays high until step 192.
- Reset mid-period: assert rst_n at step 150 with duty 0x80 -> out == 0 immediately. After release, a full 3328-clk period starts with a period_strobe pulse.
